// File: rtl/csr_access_unit.sv
// Sequencer between the execute stage and the OR-combined CSR bus: one
// CSRRW/CSRRS/CSRRC at a time, read -> optional write -> respond.
module csr_access_unit #(
    parameter bit READ_ONLY_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        requestValid,
    output logic        requestReady,
    input  logic [1:0]  requestOp,
    input  logic [11:0] requestAddress,
    input  logic [31:0] requestSource,
    input  logic        requestSourceIsZero,
    output logic        responseValid,
    input  logic        responseReady,
    output logic [31:0] responseData,
    output logic        responseIllegal,
    output logic        csrReadEnable,
    output logic [11:0] csrReadAddress,
    input  logic [31:0] csrReadData,
    input  logic        csrRequestOutput,
    output logic        csrWriteEnable,
    output logic [11:0] csrWriteAddress,
    output logic [31:0] csrWriteData
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_READ    = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_RESPOND = 2'd3;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    logic [1:0]  state_q,        state_d;
    logic [1:0]  op_q,           op_d;
    logic [11:0] addr_q,         addr_d;
    logic [31:0] src_q,          src_d;
    logic        src_zero_q,     src_zero_d;
    logic [31:0] old_q,          old_d;
    logic        req_ready_q,    req_ready_d;
    logic        rd_en_q,        rd_en_d;
    logic        wr_en_q,        wr_en_d;
    logic [31:0] wr_data_q,      wr_data_d;
    logic        resp_valid_q,   resp_valid_d;
    logic [31:0] resp_data_q,    resp_data_d;
    logic        resp_illegal_q, resp_illegal_d;

    logic        write_needed_s;
    logic        illegal_s;
    logic [31:0] new_value_s;

    // Decode of the latched operation against the live bus response during READ
    always_comb begin
        write_needed_s = (op_q == OP_RW) ||
                         (((op_q == OP_RS) || (op_q == OP_RC)) && !src_zero_q);
        illegal_s = (op_q == 2'b00) || !csrRequestOutput ||
                    ((READ_ONLY_CHECK == 1'b1) && write_needed_s && (addr_q[11:10] == 2'b11));
        case (op_q)
            OP_RW:   new_value_s = src_q;
            OP_RS:   new_value_s = csrReadData | src_q;
            OP_RC:   new_value_s = csrReadData & ~src_q;
            default: new_value_s = csrReadData;
        endcase
    end

    // Next-state and next-output computation; strobes follow the next state
    // so every bus/pipeline output comes straight from a flop.
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        addr_d         = addr_q;
        src_d          = src_q;
        src_zero_d     = src_zero_q;
        old_d          = old_q;
        wr_data_d      = wr_data_q;
        resp_data_d    = resp_data_q;
        resp_illegal_d = resp_illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (requestValid && req_ready_q) begin
                    op_d       = requestOp;
                    addr_d     = requestAddress;
                    src_d      = requestSource;
                    src_zero_d = requestSourceIsZero;
                    state_d    = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                old_d = csrReadData;
                if (illegal_s) begin
                    state_d        = ST_RESPOND;
                    resp_data_d    = 32'h0000_0000;
                    resp_illegal_d = 1'b1;
                end else if (write_needed_s) begin
                    state_d   = ST_WRITE;
                    wr_data_d = new_value_s;
                end else begin
                    state_d        = ST_RESPOND;
                    resp_data_d    = csrReadData;
                    resp_illegal_d = 1'b0;
                end
            end
            ST_WRITE: begin
                state_d        = ST_RESPOND;
                resp_data_d    = old_q;
                resp_illegal_d = 1'b0;
            end
            ST_RESPOND: begin
                if (responseReady) begin
                    state_d        = ST_IDLE;
                    resp_data_d    = 32'h0000_0000;
                    resp_illegal_d = 1'b0;
                end else begin
                    state_d = ST_RESPOND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_ready_d  = (state_d == ST_IDLE);
        rd_en_d      = (state_d == ST_READ);
        wr_en_d      = (state_d == ST_WRITE);
        resp_valid_d = (state_d == ST_RESPOND);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            op_q           <= 2'b00;
            addr_q         <= 12'h000;
            src_q          <= 32'h0000_0000;
            src_zero_q     <= 1'b0;
            old_q          <= 32'h0000_0000;
            req_ready_q    <= 1'b1;
            rd_en_q        <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_data_q      <= 32'h0000_0000;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= 32'h0000_0000;
            resp_illegal_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            addr_q         <= addr_d;
            src_q          <= src_d;
            src_zero_q     <= src_zero_d;
            old_q          <= old_d;
            req_ready_q    <= req_ready_d;
            rd_en_q        <= rd_en_d;
            wr_en_q        <= wr_en_d;
            wr_data_q      <= wr_data_d;
            resp_valid_q   <= resp_valid_d;
            resp_data_q    <= resp_data_d;
            resp_illegal_q <= resp_illegal_d;
        end
    end

    // A reset landing in the WRITE cycle must not commit the abandoned write.
    assign csrWriteEnable  = wr_en_q && !rst;
    assign requestReady    = req_ready_q;
    assign csrReadEnable   = rd_en_q;
    assign csrReadAddress  = addr_q;
    assign csrWriteAddress = addr_q;
    assign csrWriteData    = wr_data_q;
    assign responseValid   = resp_valid_q;
    assign responseData    = resp_data_q;
    assign responseIllegal = resp_illegal_q;

endmodule
